// File: rtl/test_harness.sv
// Built-in memory write/readback self-test driven by a 32-bit Galois LFSR.
// Latency: io_success rises on the (2*DEPTH+2)th edge after reset is released.
// No backpressure: the test runs free, and DONE and FAIL hold until reset.
//
// Ports:
//    clock       single clock, rising edge
//    reset       synchronous, active-high
//    io_success  high while the harness sits in DONE
//
// Optional build macro HARNESS_ERROR_INJECT_EN inverts bit 0 of the word read
// back from address 13 ahead of the compare, which forces the FAIL path.
module test_harness #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned WIDTH = 32,
   parameter logic [31:0] SEED  = 32'h0000_0001
) (
   input  logic clock,
   input  logic reset,
   output logic io_success
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [WIDTH-1:0] POLY = 32'h8020_0003;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4,
      FAIL  = 3'd5
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_dat;
   logic [WIDTH-1:0] rd_chk_dat;
   logic [WIDTH-1:0] exp_dat;
   logic [WIDTH-1:0] lfsr;
   logic [WIDTH-1:0] lfsr_nxt;
   logic [AW-1:0]    addr;
   logic             addr_last;
   logic             cmp_vld;
   logic             mismatch;
   logic             mem_we;
   logic             rd_en;

   assign lfsr_nxt  = (lfsr >> 1) ^ (lfsr[0] ? POLY : '0);
   assign addr_last = (addr == LAST_ADDR);

`ifdef HARNESS_ERROR_INJECT_EN
   // Address of the word currently on rd_dat, so the fault lands on word 13 only.
   logic [AW-1:0] cmp_addr;

   always_ff @(posedge clock) begin
      if (reset) begin
         cmp_addr <= '0;
      end else if (rd_en) begin
         cmp_addr <= addr;
      end
   end

   // Widen before comparing so small DEPTH values never alias onto 13.
   assign rd_chk_dat = rd_dat ^ {{(WIDTH-1){1'b0}}, (32'(cmp_addr) == 32'd13)};
`else
   assign rd_chk_dat = rd_dat;
`endif

   assign mismatch = cmp_vld && (rd_chk_dat != exp_dat);

   // Single-port memory with synchronous write and registered read; not reset.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[addr] <= lfsr;
      end
      if (rd_en) begin
         rd_dat <= mem[addr];
      end
   end

   // Address, LFSR and compare pipeline.
   always_ff @(posedge clock) begin
      if (reset) begin
         addr    <= '0;
         lfsr    <= SEED;
         cmp_vld <= 1'b0;
         exp_dat <= '0;
      end else begin
         // Expected value travels alongside the read so both arrive together.
         cmp_vld <= rd_en;
         if (rd_en) begin
            exp_dat <= lfsr;
         end
         case (state)
            IDLE: begin
               addr <= '0;
               lfsr <= SEED;
            end
            WRITE: begin
               // Reload the seed after the last write so READ replays the sequence.
               addr <= addr_last ? '0 : addr + 1'b1;
               lfsr <= addr_last ? SEED : lfsr_nxt;
            end
            READ: begin
               addr <= addr + 1'b1;
               lfsr <= lfsr_nxt;
            end
            default: begin
               addr <= addr;
               lfsr <= lfsr;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a mismatch overrides every other transition.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = WRITE;
         WRITE:   if (addr_last) state_nxt = READ;
         READ:    if (addr_last) state_nxt = CHECK;
         CHECK:   state_nxt = DONE;
         DONE:    state_nxt = DONE;
         FAIL:    state_nxt = FAIL;
         default: state_nxt = IDLE;
      endcase
      if (mismatch) begin
         state_nxt = FAIL;
      end
   end

   // Outputs decoded from state.
   always_comb begin
      io_success = (state == DONE);
      mem_we     = (state == WRITE);
      rd_en      = (state == READ);
   end

endmodule

// File: tb/tb_test_harness.sv
module tb_test_harness;

   localparam logic [31:0] ST_IDLE  = 32'd0;
   localparam logic [31:0] ST_WRITE = 32'd1;
   localparam logic [31:0] ST_READ  = 32'd2;
   localparam logic [31:0] ST_FAIL  = 32'd5;

`ifdef HARNESS_ERROR_INJECT_EN
   localparam bit INJ = 1'b1;
`else
   localparam bit INJ = 1'b0;
`endif

   logic clock;
   logic reset;
   logic reset4;
   logic io_success;
   logic io_success4;

   int checks = 0;
   int errors = 0;

   test_harness #(.DEPTH(64), .WIDTH(32), .SEED(32'h0000_0001)) dut (
      .clock      (clock),
      .reset      (reset),
      .io_success (io_success)
   );

   test_harness #(.DEPTH(4), .WIDTH(32), .SEED(32'h0000_0001)) dut4 (
      .clock      (clock),
      .reset      (reset4),
      .io_success (io_success4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int bad;
      int rise;

      reset  = 1'b1;
      reset4 = 1'b1;
      repeat (10) step();
      check("rst_success", 32'(io_success), 32'd0);
      check("rst_state", 32'(dut.state), ST_IDLE);
      check("rst_addr", 32'(dut.addr), 32'd0);
      check("rst_lfsr", dut.lfsr, 32'h0000_0001);
      check("rst_cmp_vld", 32'(dut.cmp_vld), 32'd0);

      // Normal run: edge 1 is the first edge with reset low.
      reset = 1'b0;
      bad = 0;
      for (int e = 1; e <= 140; e++) begin
         step();
         if (e == 1) check("edge1_write", 32'(dut.state), ST_WRITE);
         if (e == 65) begin
            check("mem0", dut.mem[0], 32'h0000_0001);
            check("mem1", dut.mem[1], 32'h8020_0003);
            check("mem2", dut.mem[2], 32'hC030_0002);
            check("mem3", dut.mem[3], 32'h6018_0001);
            check("edge65_read", 32'(dut.state), ST_READ);
         end
         if (INJ) begin
            if (e == 79) check("edge79_not_fail", 32'(dut.state == 3'd5), 32'd0);
            if (e == 80) check("edge80_fail", 32'(dut.state), ST_FAIL);
         end
         if (e < 130 && io_success) bad++;
         if (e == 129) check("edge129_success", 32'(io_success), 32'd0);
         if (e == 130) check("edge130_success", 32'(io_success), INJ ? 32'd0 : 32'd1);
      end
      check("early_success", 32'(bad), 32'd0);
      check("edge140_success", 32'(io_success), INJ ? 32'd0 : 32'd1);

      if (INJ) begin
         bad = 0;
         for (int i = 0; i < 1000; i++) begin
            step();
            if (io_success || dut.state != 3'd5) bad++;
         end
         check("inj_stays_fail", 32'(bad), 32'd0);
      end

      // Held reset for 500 cycles.
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         step();
         if (io_success || dut.state != 3'd0) bad++;
      end
      check("held_reset", 32'(bad), 32'd0);

      // Reset pulse during READ at edge 90.
      reset = 1'b0;
      repeat (89) step();
      check("edge89_read", 32'(dut.state), INJ ? ST_FAIL : ST_READ);
      reset = 1'b1;
      step();
      check("midrun_idle", 32'(dut.state), ST_IDLE);
      reset = 1'b0;
      rise = -1;
      for (int e = 1; e <= 200; e++) begin
         step();
         if (io_success && rise < 0) rise = e;
      end
      check("midrun_rise_edge", 32'(rise), INJ ? 32'hFFFF_FFFF : 32'd130);

      // DEPTH=4 variant: success at edge 2*4+2 = 10.
      reset4 = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         step();
         if (e == 9)  check("d4_edge9", 32'(io_success4), 32'd0);
         if (e == 10) check("d4_edge10", 32'(io_success4), 32'd1);
      end
      check("d4_hold", 32'(io_success4), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
